// File: rtl/crc8_frame_ctrl.sv
// Frame sequencer for a byte-serial CRC-8 engine: streams payload through the engine,
// appends the CRC byte, and enforces a maximum frame length and an engine timeout.
module crc8_frame_ctrl #(
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        m_err,
    output logic        eng_clr,
    output logic        eng_start,
    output logic [7:0]  eng_byte,
    input  logic        eng_done,
    input  logic [7:0]  eng_crc,
    output logic        err_len,
    output logic        err_timeout,
    output logic [15:0] frame_cnt
);
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;
    localparam int unsigned FW = 16;
    localparam logic [CW-1:0] LEN_LAST = CW'(MAX_LEN - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, ACCEPT, BUSY, OUT, CRC, ABORT, FLUSH, CLEAR
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] byte_q, byte_d, crc_q, crc_d, eng_byte_q, eng_byte_d, m_data_q, m_data_d;
    logic [CW-1:0] len_cnt_q, len_cnt_d, tmo_cnt_q, tmo_cnt_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          last_q, last_d, trunc_q, trunc_d;
    logic          s_ready_q, s_ready_d, m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic          m_err_q, m_err_d, eng_clr_q, eng_clr_d, eng_start_q, eng_start_d;
    logic          err_len_q, err_len_d, err_tmo_q, err_tmo_d;
    logic          s_hs_c, m_hs_c, at_len_last_c;

    assign s_hs_c        = s_valid && s_ready_q;
    assign m_hs_c        = m_valid_q && m_ready;
    assign at_len_last_c = (len_cnt_q == LEN_LAST);

    // Next state, datapath updates and output decode from the next state
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        crc_d       = crc_q;
        eng_byte_d  = eng_byte_q;
        len_cnt_d   = len_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        frame_cnt_d = frame_cnt_q;
        last_d      = last_q;
        trunc_d     = trunc_q;
        err_len_d   = 1'b0;
        err_tmo_d   = 1'b0;

        unique case (state_q)
            IDLE: state_d = ACCEPT;
            ACCEPT: begin
                if (s_hs_c) begin
                    byte_d     = s_data;
                    eng_byte_d = s_data;
                    last_d     = s_last || at_len_last_c;
                    trunc_d    = at_len_last_c && !s_last;
                    err_len_d  = at_len_last_c && !s_last;
                    len_cnt_d  = len_cnt_q + CW'(1);
                    tmo_cnt_d  = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // A done arriving on the expiry edge still wins
                if (eng_done) begin
                    crc_d   = eng_crc;
                    state_d = OUT;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_tmo_d = 1'b1;
                    state_d   = ABORT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CW'(1);
                end
            end
            OUT:   if (m_hs_c) state_d = last_q ? CRC : ACCEPT;
            CRC:   if (m_hs_c) state_d = trunc_q ? FLUSH : CLEAR;
            ABORT: if (m_hs_c) state_d = last_q ? CLEAR : FLUSH;
            FLUSH: if (s_hs_c && s_last) state_d = CLEAR;
            CLEAR: begin
                len_cnt_d   = '0;
                trunc_d     = 1'b0;
                last_d      = 1'b0;
                frame_cnt_d = frame_cnt_q + FW'(1);
                state_d     = ACCEPT;
            end
            default: state_d = IDLE;
        endcase

        s_ready_d   = (state_d == ACCEPT) || (state_d == FLUSH);
        m_valid_d   = (state_d == OUT) || (state_d == CRC) || (state_d == ABORT);
        m_last_d    = (state_d == CRC) || (state_d == ABORT);
        m_err_d     = (state_d == ABORT);
        eng_clr_d   = (state_d == CLEAR);
        eng_start_d = (state_q == ACCEPT) && (state_d == BUSY);
        unique case (state_d)
            OUT:     m_data_d = byte_d;
            CRC:     m_data_d = crc_d;
            default: m_data_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_q      <= '0;
            crc_q       <= '0;
            eng_byte_q  <= '0;
            len_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            frame_cnt_q <= '0;
            last_q      <= 1'b0;
            trunc_q     <= 1'b0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            m_err_q     <= 1'b0;
            eng_clr_q   <= 1'b0;
            eng_start_q <= 1'b0;
            err_len_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            crc_q       <= crc_d;
            eng_byte_q  <= eng_byte_d;
            len_cnt_q   <= len_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            last_q      <= last_d;
            trunc_q     <= trunc_d;
            s_ready_q   <= s_ready_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            m_err_q     <= m_err_d;
            eng_clr_q   <= eng_clr_d;
            eng_start_q <= eng_start_d;
            err_len_q   <= err_len_d;
            err_tmo_q   <= err_tmo_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_last      = m_last_q;
    assign m_err       = m_err_q;
    assign eng_clr     = eng_clr_q;
    assign eng_start   = eng_start_q;
    assign eng_byte    = eng_byte_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_tmo_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// Bench for crc8_frame_ctrl: CRC-8 (poly 0x07) engine model plus an output scoreboard.
module tb_crc8_frame_ctrl;
    localparam int unsigned MAX_LEN = 9;
    localparam int unsigned TIMEOUT = 32;

    logic        clk, rst_n;
    logic        s_valid, s_ready, s_last, m_valid, m_ready, m_last, m_err;
    logic [7:0]  s_data, m_data, eng_byte, eng_crc;
    logic        eng_clr, eng_start, eng_done, err_len, err_timeout;
    logic [15:0] frame_cnt;

    typedef struct packed { logic [7:0] data; logic last; logic err; } beat_t;
    beat_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int eng_lat = 8;
    int start_num = 0;
    int drop_num = -1;
    int last_start_cyc = 0;
    int n_err_len = 0;
    int n_err_tmo = 0;
    int n_clr = 0;
    logic [15:0] exp_frames = 16'h0;
    logic [7:0]  eng_acc, eng_pend;
    int          eng_cnt;
    bit          eng_drop;

    crc8_frame_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_err(m_err),
        .eng_clr(eng_clr), .eng_start(eng_start), .eng_byte(eng_byte),
        .eng_done(eng_done), .eng_crc(eng_crc),
        .err_len(err_len), .err_timeout(err_timeout), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    // Engine model: latency eng_lat cycles after eng_start; one selected start can be dropped
    initial begin
        eng_done = 1'b0; eng_crc = 8'h0; eng_acc = 8'h0; eng_pend = 8'h0; eng_cnt = 0; eng_drop = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                eng_done = 1'b0; eng_acc = 8'h0; eng_cnt = 0; eng_drop = 0;
                continue;
            end
            #1;
            eng_done = 1'b0;
            if (eng_clr) begin
                eng_acc = 8'h0; eng_cnt = 0;
            end else if (eng_start) begin
                start_num++;
                last_start_cyc = cyc;
                eng_drop = (start_num == drop_num);
                eng_pend = eng_byte;
                eng_cnt = eng_lat;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0 && !eng_drop) begin
                    eng_acc  = crc8_upd(eng_acc, eng_pend);
                    eng_crc  = eng_acc;
                    eng_done = 1'b1;
                end
            end
        end
    end

    // Output monitor: scoreboard pops on every downstream handshake, pulse counters
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (err_len) n_err_len++;
                if (eng_clr) n_clr++;
                if (err_timeout) begin
                    n_err_tmo++;
                    checks++;
                    if (cyc - last_start_cyc != int'(TIMEOUT)) begin
                        errors++;
                        $display("FAIL tmo_latency: got %0d cycles after eng_start, required %0d",
                                 cyc - last_start_cyc, TIMEOUT);
                    end
                end
                if (m_valid && m_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL out_unexpected: got data=%h last=%b err=%b, required no output",
                                 m_data, m_last, m_err);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_data, m_last, m_err} !== {e.data, e.last, e.err}) begin
                            errors++;
                            $display("FAIL out_beat: got data=%h last=%b err=%b, required data=%h last=%b err=%b",
                                     m_data, m_last, m_err, e.data, e.last, e.err);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int t = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!s_ready && t < 200) begin tick(); t++; end
        if (!s_ready) begin
            checks++; errors++;
            $display("FAIL send_wait: s_ready=%b after %0d cycles, required 1", s_ready, t);
        end else begin
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_frames(input string name);
        int t = 0;
        while ((frame_cnt !== exp_frames || exp_q.size() != 0) && t < 400) begin tick(); t++; end
        checks++;
        if (frame_cnt !== exp_frames || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_frame_end: frame_cnt=%h pending=%0d, required frame_cnt=%h pending=0",
                     name, frame_cnt, exp_q.size(), exp_frames);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #30;
        checks++;
        if ({s_ready, m_valid, m_data, m_last, m_err, eng_clr, eng_start, eng_byte,
             err_len, err_timeout, frame_cnt} !== 40'h0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs s_ready=%b m_valid=%b frame_cnt=%h, required all 0",
                     s_ready, m_valid, frame_cnt);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_idle: s_ready=%b, required 0", s_ready); end
        tick();
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_accept: s_ready=%b, required 1", s_ready); end
    endtask

    task automatic test_check_string();
        int clr0 = n_clr;
        int len0 = n_err_len;
        m_ready = 1'b1;
        for (int i = 0; i < 9; i++) exp_q.push_back({8'(32'h31 + i), 1'b0, 1'b0});
        exp_q.push_back({8'hF4, 1'b1, 1'b0});
        exp_frames++;
        for (int i = 0; i < 9; i++) begin
            send_byte(8'(32'h31 + i), i == 8);
            if (i == 0) begin
                checks++;
                if (eng_start !== 1'b1 || eng_byte !== 8'h31) begin
                    errors++;
                    $display("FAIL start_pulse: eng_start=%b eng_byte=%h, required 1 and 31", eng_start, eng_byte);
                end
                tick();
                checks++;
                if (eng_start !== 1'b0) begin
                    errors++;
                    $display("FAIL start_width: eng_start=%b in 2nd BUSY cycle, required 0", eng_start);
                end
            end
        end
        wait_frames("check_string");
        checks++;
        if (n_clr - clr0 != 1 || n_err_len != len0) begin
            errors++;
            $display("FAIL check_string_pulses: clr=%0d err_len=%0d, required clr=1 err_len=0",
                     n_clr - clr0, n_err_len - len0);
        end
    endtask

    task automatic test_stall();
        int t = 0;
        bit bad = 0;
        m_ready = 1'b0;
        exp_q.push_back({8'h01, 1'b0, 1'b0});
        exp_q.push_back({8'h07, 1'b1, 1'b0});
        exp_frames++;
        send_byte(8'h01, 1'b1);
        s_valid = 1'b1; s_data = 8'hEE; s_last = 1'b1;
        while (!m_valid && t < 50) begin tick(); t++; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid !== 1'b1 || m_data !== 8'h01 || m_last !== 1'b0 || s_ready !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stall_hold: m_valid=%b m_data=%h s_ready=%b, required 1 01 0 throughout",
                     m_valid, m_data, s_ready);
        end
        @(posedge clk); #1; m_ready = 1'b1;
        t = 0; bad = 0;
        while (!eng_clr && t < 50) begin
            if (s_ready) bad = 1;
            tick(); t++;
        end
        checks++;
        if (bad || !eng_clr) begin
            errors++;
            $display("FAIL stall_sready: s_ready_seen=%b eng_clr=%b, required 0 and 1", bad, eng_clr);
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick();
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL stall_reaccept: s_ready=%b, required 1", s_ready); end
        wait_frames("stall");
    endtask

    task automatic test_truncate();
        logic [7:0] c = 8'h0;
        int len0 = n_err_len;
        int st0 = start_num;
        m_ready = 1'b1;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            exp_q.push_back({8'(i), 1'b0, 1'b0});
            c = crc8_upd(c, 8'(i));
        end
        exp_q.push_back({c, 1'b1, 1'b0});
        exp_frames++;
        for (int i = 0; i < int'(MAX_LEN) + 2; i++) begin
            send_byte(8'(i), i == int'(MAX_LEN) + 1);
            if (i == int'(MAX_LEN) - 1) begin
                checks++;
                if (err_len !== 1'b1) begin errors++; $display("FAIL trunc_pulse: err_len=%b, required 1", err_len); end
            end
        end
        wait_frames("truncate");
        checks++;
        if (n_err_len - len0 != 1 || start_num - st0 != int'(MAX_LEN)) begin
            errors++;
            $display("FAIL trunc_counts: err_len=%0d starts=%0d, required 1 and %0d",
                     n_err_len - len0, start_num - st0, MAX_LEN);
        end
        exp_q.push_back({8'h31, 1'b0, 1'b0});
        exp_q.push_back({8'h97, 1'b1, 1'b0});
        exp_frames++;
        send_byte(8'h31, 1'b1);
        wait_frames("after_trunc");
    endtask

    task automatic test_timeout();
        int tmo0 = n_err_tmo;
        int st0 = start_num;
        m_ready = 1'b1;
        drop_num = start_num + 2;
        exp_q.push_back({8'h11, 1'b0, 1'b0});
        exp_q.push_back({8'h00, 1'b1, 1'b1});
        exp_frames++;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        wait_frames("timeout");
        checks++;
        if (n_err_tmo - tmo0 != 1 || start_num - st0 != 2) begin
            errors++;
            $display("FAIL timeout_counts: err_timeout=%0d starts=%0d, required 1 and 2",
                     n_err_tmo - tmo0, start_num - st0);
        end
        drop_num = -1;
    endtask

    task automatic test_done_at_expiry();
        int tmo0 = n_err_tmo;
        eng_lat = int'(TIMEOUT) - 1;
        exp_q.push_back({8'h5A, 1'b0, 1'b0});
        exp_q.push_back({crc8_upd(8'h00, 8'h5A), 1'b1, 1'b0});
        exp_frames++;
        send_byte(8'h5A, 1'b1);
        wait_frames("done_at_expiry");
        checks++;
        if (n_err_tmo != tmo0) begin
            errors++;
            $display("FAIL expiry_race: err_timeout=%0d, required 0", n_err_tmo - tmo0);
        end
        eng_lat = 8;
    endtask

    task automatic test_reset_midframe();
        int t = 0;
        exp_q.push_back({8'h41, 1'b0, 1'b0});
        send_byte(8'h41, 1'b0);
        while (exp_q.size() != 0 && t < 100) begin tick(); t++; end
        send_byte(8'h42, 1'b0);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, m_valid, m_data, m_last, m_err, eng_clr, eng_start, eng_byte,
             err_len, err_timeout, frame_cnt} !== 40'h0) begin
            errors++;
            $display("FAIL midreset_outputs: s_ready=%b m_valid=%b eng_byte=%h frame_cnt=%h, required all 0",
                     s_ready, m_valid, eng_byte, frame_cnt);
        end
        exp_q.delete();
        exp_frames = 16'h0;
        @(posedge clk); #1; rst_n = 1'b1;
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL midreset_idle: s_ready=%b, required 0", s_ready); end
        tick();
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL midreset_accept: s_ready=%b, required 1", s_ready); end
        exp_q.push_back({8'h31, 1'b0, 1'b0});
        exp_q.push_back({8'h97, 1'b1, 1'b0});
        exp_frames++;
        send_byte(8'h31, 1'b1);
        wait_frames("after_reset");
    endtask

    task automatic test_wrap();
        @(posedge clk); #1;
        force dut.frame_cnt_q = 16'hFFFF;
        tick();
        release dut.frame_cnt_q;
        exp_frames = 16'hFFFF;
        exp_q.push_back({8'h31, 1'b0, 1'b0});
        exp_q.push_back({8'h97, 1'b1, 1'b0});
        exp_frames++;
        send_byte(8'h31, 1'b1);
        wait_frames("wrap");
    endtask

    initial begin
        rst_n = 1'b1; s_valid = 1'b0; s_data = 8'h0; s_last = 1'b0; m_ready = 1'b0;
        #2 rst_n = 1'b0;
        test_reset();
        test_check_string();
        test_stall();
        test_truncate();
        test_timeout();
        test_done_at_expiry();
        test_reset_midframe();
        test_wrap();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
